// File: rtl/music_pkg.sv
// Shared encodings for the note PROM arbiter: FSM states and return-tag values.
package music_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_LD   = 2'd1,
        TAG_KB   = 2'd2
    } tag_t;

endpackage

// File: rtl/note_tag_pipe.sv
// Owner-tag shift register that tracks each PROM read in flight, so the result
// can be steered to the requester that issued it.
module note_tag_pipe
    import music_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] tag_i,
    output logic [1:0] tag_o,
    output logic       busy_o
);

    logic [1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i] != TAG_NONE) begin
                busy_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_rom_arbiter.sv
// Shares the single-port note PROM between the song loader (LD) and keyboard (KB):
// round-robin arbitration, loader burst lock with a starvation bound, tagged return.
module note_rom_arbiter
    import music_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ld_req,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    input  logic              kb_req,
    input  logic [ADDR_W-1:0] kb_addr,
    output logic              kb_gnt,
    output logic              kb_valid,
    output logic [DATA_W-1:0] kb_data,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              busy
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic              rr_kb_q;
    logic [7:0]        cnt_q, cnt_d;
    logic              gnt_ld, gnt_kb;
    logic [1:0]        tag_in, tag_out;
    logic              pipe_busy;
    logic [ADDR_W-1:0] rom_ad_q;
    logic              rom_ce_q;
    logic              ld_valid_q, kb_valid_q;
    logic [DATA_W-1:0] ld_data_q, kb_data_q;

    // The burst rules only apply while the lock is still held; a dropped lock
    // falls straight through to plain round-robin in the same cycle.
    always_comb begin
        gnt_ld  = 1'b0;
        gnt_kb  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_BURST && ld_lock) begin
            if (ld_req) begin
                if (cnt_q == MAX_CNT && kb_req) begin
                    gnt_kb = 1'b1;
                    cnt_d  = 8'd0;
                end else begin
                    gnt_ld = 1'b1;
                    if (cnt_q != MAX_CNT) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end else if (kb_req) begin
                gnt_kb = 1'b1;
            end
        end else begin
            state_d = ST_ARB;
            cnt_d   = 8'd0;
            if (ld_req && (!kb_req || !rr_kb_q)) begin
                gnt_ld = 1'b1;
            end else if (kb_req) begin
                gnt_kb = 1'b1;
            end
            if (gnt_ld && ld_lock) begin
                state_d = ST_BURST;
                cnt_d   = 8'd1;
            end
        end
    end

    assign tag_in = gnt_ld ? TAG_LD : (gnt_kb ? TAG_KB : TAG_NONE);

    note_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .tag_i  (tag_in),
        .tag_o  (tag_out),
        .busy_o (pipe_busy)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_ARB;
            rr_kb_q    <= 1'b0;
            cnt_q      <= 8'd0;
            rom_ad_q   <= '0;
            rom_ce_q   <= 1'b0;
            ld_valid_q <= 1'b0;
            kb_valid_q <= 1'b0;
            ld_data_q  <= '0;
            kb_data_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rom_ce_q <= gnt_ld | gnt_kb;
            if (gnt_ld) begin
                rr_kb_q  <= 1'b1;
                rom_ad_q <= ld_addr;
            end else if (gnt_kb) begin
                rr_kb_q  <= 1'b0;
                rom_ad_q <= kb_addr;
            end
            ld_valid_q <= (tag_out == TAG_LD);
            kb_valid_q <= (tag_out == TAG_KB);
            if (tag_out == TAG_LD) begin
                ld_data_q <= rom_dout;
            end
            if (tag_out == TAG_KB) begin
                kb_data_q <= rom_dout;
            end
        end
    end

    // Grants are combinational, so they are masked while reset is asserted.
    assign ld_gnt   = gnt_ld & ~sys_rst;
    assign kb_gnt   = gnt_kb & ~sys_rst;
    assign busy     = ld_gnt | kb_gnt | pipe_busy;
    assign rom_ce   = rom_ce_q;
    assign rom_ad   = rom_ad_q;
    assign ld_valid = ld_valid_q;
    assign kb_valid = kb_valid_q;
    assign ld_data  = ld_data_q;
    assign kb_data  = kb_data_q;

endmodule

// File: tb/tb_note_rom_arbiter.sv
// Directed bench for note_rom_arbiter with a 1-cycle PROM model (dout = addr*3)
// and a scoreboard of expected returns keyed by the cycle they are due.
module tb_note_rom_arbiter;
  import music_pkg::*;

  localparam int W = 50;  // {tag[1:0], due_cycle[31:0], data[15:0]}

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ld_req, ld_lock, kb_req;
  logic [6:0]  ld_addr, kb_addr;
  logic        ld_gnt, ld_valid, kb_gnt, kb_valid;
  logic [15:0] ld_data, kb_data;
  logic        rom_ce, busy;
  logic [6:0]  rom_ad;
  logic [15:0] rom_dout = 16'd0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [15:0]  last_ld = 16'd0;
  logic [15:0]  last_kb = 16'd0;
  logic [6:0]   last_ad = 7'd0;
  logic [6:0]   ra, rb;

  // clock / reset block
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // PROM model, one cycle read latency
  always @(posedge sys_clk) rom_dout <= 16'(rom_ad) * 16'd3;

  note_rom_arbiter #(
    .ADDR_W    (7),
    .DATA_W    (16),
    .RD_LAT    (1),
    .MAX_BURST (4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ld_req   (ld_req),
    .ld_lock  (ld_lock),
    .ld_addr  (ld_addr),
    .ld_gnt   (ld_gnt),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .kb_req   (kb_req),
    .kb_addr  (kb_addr),
    .kb_gnt   (kb_gnt),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .rom_ce   (rom_ce),
    .rom_ad   (rom_ad),
    .rom_dout (rom_dout),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // driver: apply one cycle of requests, check grants, queue the expected return
  task automatic step(input string name, input logic lr, input logic ll, input logic [6:0] la,
                      input logic kr, input logic [6:0] ka, input logic eld, input logic ekb);
    ld_req  = lr;
    ld_lock = ll;
    ld_addr = la;
    kb_req  = kr;
    kb_addr = ka;
    @(negedge sys_clk);
    check({name, ".ld_gnt"}, 32'(ld_gnt), 32'(eld));
    check({name, ".kb_gnt"}, 32'(kb_gnt), 32'(ekb));
    if (eld) begin
      exp_q.push_back({TAG_LD, 32'(cyc + 3), 16'(la) * 16'd3});
      last_ad = la;
    end
    if (ekb) begin
      exp_q.push_back({TAG_KB, 32'(cyc + 3), 16'(ka) * 16'd3});
      last_ad = ka;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0);
  endtask

  // scoreboard: every cycle either the queue head is due now or no valid may appear
  always @(negedge sys_clk) begin
    if (exp_q.size() != 0 && exp_q[0][47:16] == 32'(cyc)) begin
      mon_e = exp_q.pop_front();
      if (mon_e[49:48] == TAG_LD) begin
        check("ret.ld_valid", 32'(ld_valid), 32'd1);
        check("ret.kb_quiet", 32'(kb_valid), 32'd0);
        check("ret.ld_data", 32'(ld_data), 32'(mon_e[15:0]));
        last_ld = mon_e[15:0];
      end else begin
        check("ret.kb_valid", 32'(kb_valid), 32'd1);
        check("ret.ld_quiet", 32'(ld_valid), 32'd0);
        check("ret.kb_data", 32'(kb_data), 32'(mon_e[15:0]));
        last_kb = mon_e[15:0];
      end
    end else begin
      check("noret.ld_valid", 32'(ld_valid), 32'd0);
      check("noret.kb_valid", 32'(kb_valid), 32'd0);
    end
  end

  initial begin
    // reset with both requests asserted: everything must read zero
    sys_rst = 1'b1;
    ld_req  = 1'b1;
    kb_req  = 1'b1;
    ld_lock = 1'b1;
    ld_addr = 7'h55;
    kb_addr = 7'h2A;
    @(negedge sys_clk);
    check("rst.ld_gnt", 32'(ld_gnt), 32'd0);
    check("rst.kb_gnt", 32'(kb_gnt), 32'd0);
    check("rst.rom_ce", 32'(rom_ce), 32'd0);
    check("rst.rom_ad", 32'(rom_ad), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.ld_data", 32'(ld_data), 32'd0);
    check("rst.kb_data", 32'(kb_data), 32'd0);
    @(posedge sys_clk);
    #1;
    ld_req  = 1'b0;
    kb_req  = 1'b0;
    ld_lock = 1'b0;
    sys_rst = 1'b0;
    idle(2);

    // single keyboard lookup: address on PROM next cycle, result 3 cycles after grant
    step("kb_single", 1'b0, 1'b0, 7'd0, 1'b1, 7'h3C, 1'b0, 1'b1);
    ld_req = 1'b0;
    kb_req = 1'b0;
    @(negedge sys_clk);
    check("kb_single.rom_ce", 32'(rom_ce), 32'd1);
    check("kb_single.rom_ad", 32'(rom_ad), 32'h3C);
    check("kb_single.busy", 32'(busy), 32'd1);
    @(posedge sys_clk);
    #1;
    idle(3);
    check("kb_single.kb_data", 32'(kb_data), 32'h00B4);

    // both requesting, no lock: strict alternation starting with LD
    for (int i = 0; i < 8; i++) begin
      ra = 7'($urandom_range(0, 127));
      rb = 7'($urandom_range(0, 127));
      step("alt", 1'b1, 1'b0, ra, 1'b1, rb, (i % 2) == 0, (i % 2) == 1);
    end

    // lock held with KB waiting: four LD grants, one KB, repeating
    for (int i = 0; i < 10; i++) begin
      ra = 7'($urandom_range(0, 127));
      rb = 7'($urandom_range(0, 127));
      step("burst", 1'b1, 1'b1, ra, 1'b1, rb, (i % 5) != 4, (i % 5) == 4);
    end

    // lock dropped: alternation resumes
    for (int i = 0; i < 4; i++) begin
      ra = 7'($urandom_range(0, 127));
      rb = 7'($urandom_range(0, 127));
      step("unlock", 1'b1, 1'b0, ra, 1'b1, rb, (i % 2) == 0, (i % 2) == 1);
    end

    // lock held, LD pauses 2 cycles: KB served, burst count must not move
    begin
      logic [7:0] lr_pat, kb_pat;
      lr_pat = 8'b1111_0011;  // bit i = ld_req in step i
      kb_pat = 8'b0100_1100;  // bit i = expected kb grant in step i
      for (int i = 0; i < 8; i++) begin
        ra = 7'($urandom_range(0, 127));
        rb = 7'($urandom_range(0, 127));
        step("pause", lr_pat[i], 1'b1, ra, 1'b1, rb, !kb_pat[i], kb_pat[i]);
      end
    end
    idle(4);

    // reset one cycle after an LD grant: that read must never return
    step("pre_rst", 1'b1, 1'b0, 7'h11, 1'b0, 7'd0, 1'b1, 1'b0);
    sys_rst = 1'b1;
    exp_q.delete();
    last_ld = 16'd0;
    last_kb = 16'd0;
    last_ad = 7'd0;
    ld_req  = 1'b1;
    kb_req  = 1'b1;
    @(negedge sys_clk);
    check("mid_rst.ld_gnt", 32'(ld_gnt), 32'd0);
    check("mid_rst.kb_gnt", 32'(kb_gnt), 32'd0);
    check("mid_rst.rom_ce", 32'(rom_ce), 32'd0);
    check("mid_rst.rom_ad", 32'(rom_ad), 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    check("mid_rst.ld_data", 32'(ld_data), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    step("post_rst_tie", 1'b1, 1'b0, 7'h21, 1'b1, 7'h42, 1'b1, 1'b0);
    step("post_rst_2nd", 1'b1, 1'b0, 7'h22, 1'b1, 7'h43, 1'b0, 1'b1);

    // long idle: PROM disabled, address and return data held
    idle(20);
    check("idle.rom_ce", 32'(rom_ce), 32'd0);
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.rom_ad", 32'(rom_ad), 32'(last_ad));
    check("idle.ld_data", 32'(ld_data), 32'(last_ld));
    check("idle.kb_data", 32'(kb_data), 32'(last_kb));
    check("idle.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
